dac_ramp_controller: RTL
========================

Name: dac_ramp_controller

Overview:
- Slew-limited sequencer for the analog output stage: accepts target codes over a valid/ready handshake and ramps an unsigned DAC code toward each target in bounded steps at a fixed step rate.
- After each ramp, waits a programmable settling time, then pulses settled.
- Sits between digital control logic and the real-valued DAC/DUT model; the bench converts dac_code to vout as code*VREF/2**CODE_WIDTH.

Parameters:
CODE_WIDTH, 8, width of target and DAC codes (unsigned), >=2
STEP_MAX, 4, max code change per step, 1..2**CODE_WIDTH-1
STEP_DIV, 4, clock cycles between successive steps, >=1
SETTLE_CYCLES, 8, clock cycles from final step (or no-op accept) to settled, >=1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
target_valid  in  1  target_code offered
target_ready  out  1  controller can accept a target
target_code  in  CODE_WIDTH  requested DAC code
abort  in  1  cancel current ramp/settle
dac_code  out  CODE_WIDTH  current code driven to DAC, registered
dac_update  out  1  one-cycle pulse, high in the cycle dac_code holds a newly stepped value
busy  out  1  high in RAMP or SETTLE
settled  out  1  one-cycle pulse on completion

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, dac_code=0, dac_update=0, busy=0, settled=0, target_ready=1, counter=0, latched target=0.
- States: IDLE, RAMP, SETTLE. target_ready=1 iff IDLE; busy=1 iff RAMP or SETTLE; all outputs registered or state-decoded, no input-to-output combinational paths.
- IDLE: on edge k with target_valid&target_ready, latch target.
  - If target != dac_code: go RAMP, counter=STEP_DIV-1.
  - Otherwise: go SETTLE, counter=SETTLE_CYCLES-1.
  - abort is ignored in IDLE, including when it coincides with an accept.
- RAMP: each edge, if counter != 0, decrement. If counter == 0, step:
  - delta = target - dac_code, computed signed at CODE_WIDTH+1 bits.
  - If |delta| <= STEP_MAX, dac_code = target; else dac_code += sign(delta)*STEP_MAX.
  - Pulse dac_update for one cycle.
  - If the new code equals target, go SETTLE with counter=SETTLE_CYCLES-1; else reload counter=STEP_DIV-1.
  - First step lands at edge k+STEP_DIV, subsequent steps every STEP_DIV edges.
  - No wrap-around: clamping to target keeps the code within 0..2**CODE_WIDTH-1.
- SETTLE: decrement each edge. At counter == 0, go IDLE and set settled=1 for exactly one cycle, the first IDLE cycle. Settled is high during the cycle after edge m+SETTLE_CYCLES, where m is the final-step or accept edge.
  - A target offered in that cycle is accepted normally. settled still drops next cycle.
- abort in RAMP or SETTLE: go IDLE at that edge, dac_code holds its last value, no dac_update, no settled pulse. abort on the same edge as a step still cancels the step, so dac_code is unchanged.
- target_valid while busy: not accepted. target_code may change freely; the latched target is unaffected.
- rst asserted mid-operation: immediately returns to reset values; no settled pulse.

Test Plan:
- Reset with defaults -> dac_code=0, dac_update=0, busy=0, settled=0, target_ready=1; same values when rst is asserted asynchronously mid-cycle.
- Accept target 10 at edge k from code 0 -> dac_update pulses with dac_code 4,8,10 after edges k+4,k+8,k+12; busy high throughout; settled pulses after edge k+20; target_ready=1 in that cycle.
- From code 10, accept target 1 -> codes 6,2,1 at 4-cycle spacing; settled 8 cycles after code reaches 1; no underflow.
- From code 10, accept target 10 -> no dac_update; SETTLE only; settled pulses after edge k+8.
- Accept target 200 from 0; assert abort one cycle after second update (code 8) -> IDLE next edge; dac_code stays 8; no settled. Then accept target 12 -> update to 12 after 4 edges; settled 8 edges later.
- Hold target_valid with changing target_code during a ramp to 20 -> no accept while busy; ramp ends at 20. Offer abort and valid together in IDLE -> target accepted.

Source files
------------

// File: rtl/dac_ramp_controller_if.sv
// Target handshake between control logic and the DAC ramp controller.
interface dac_ramp_controller_if #(
  parameter int CODE_WIDTH = 8
);
  logic                  target_valid;
  logic                  target_ready;
  logic [CODE_WIDTH-1:0] target_code;

  modport master (
    output target_valid,
    output target_code,
    input  target_ready
  );

  modport slave (
    input  target_valid,
    input  target_code,
    output target_ready
  );
endinterface

// File: rtl/dac_ramp_controller.sv
// Slew-limited DAC sequencer: ramps dac_code toward each accepted target in
// steps of at most STEP_MAX every STEP_DIV cycles, then pulses settled.
module dac_ramp_controller #(
  parameter int CODE_WIDTH    = 8,
  parameter int STEP_MAX      = 4,
  parameter int STEP_DIV      = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  dac_ramp_controller_if.slave    target,
  input  logic                    abort,
  output logic [CODE_WIDTH-1:0]   dac_code,
  output logic                    dac_update,
  output logic                    busy,
  output logic                    settled
);

  localparam int CNT_MAX = (STEP_DIV > SETTLE_CYCLES) ? STEP_DIV : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      DIV_LOAD    = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CODE_WIDTH-1:0] STEP_CODE   = CODE_WIDTH'(STEP_MAX);
  localparam logic [CODE_WIDTH:0]   STEP_EXT    = {1'b0, STEP_CODE};

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        counter;
  logic [CODE_WIDTH-1:0]   target_q;

  logic signed [CODE_WIDTH:0] delta;
  logic [CODE_WIDTH:0]        mag;
  logic [CODE_WIDTH-1:0]      next_code;

  // Clamp to the target whenever the remaining distance fits in one step,
  // so the code never over- or under-shoots the 0..2**CODE_WIDTH-1 range.
  always_comb begin
    delta     = $signed({1'b0, target_q}) - $signed({1'b0, dac_code});
    mag       = delta[CODE_WIDTH] ? $unsigned(-delta) : $unsigned(delta);
    next_code = target_q;
    if (mag > STEP_EXT) begin
      if (delta[CODE_WIDTH]) next_code = dac_code - STEP_CODE;
      else                   next_code = dac_code + STEP_CODE;
    end
  end

  assign target.target_ready = (state == IDLE);
  assign busy                = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      target_q   <= '0;
      dac_code   <= '0;
      dac_update <= 1'b0;
      settled    <= 1'b0;
    end else begin
      dac_update <= 1'b0;
      settled    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (target.target_valid) begin
            target_q <= target.target_code;
            if (target.target_code != dac_code) begin
              state   <= RAMP;
              counter <= DIV_LOAD;
            end else begin
              state   <= SETTLE;
              counter <= SETTLE_LOAD;
            end
          end
        end
        RAMP: begin
          if (abort) begin
            state <= IDLE;
          end else if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            dac_code   <= next_code;
            dac_update <= 1'b1;
            if (next_code == target_q) begin
              state   <= SETTLE;
              counter <= SETTLE_LOAD;
            end else begin
              counter <= DIV_LOAD;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
          end else if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            state   <= IDLE;
            settled <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
